dual_port_sync_ram: RTL and testbench

Parametrised true dual-port synchronous RAM, the successor to the single-port sync RAM. It has two independent read/write ports (A, B), byte-lane write enables and a configurable registered read latency. Read-data outputs are unidirectional, with rvalid strobes instead of a tri-state data bus. A built-in clear sequencer zeroes the array after reset. It serves as shared storage between the CPU datapath and a second master such as DMA or a debug loader.

---
 rtl/dual_port_sync_ram_if.sv | 36 +++
 rtl/dual_port_sync_ram.sv | 205 ++++++++++++++++++++
 tb/tb_dual_port_sync_ram.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_port_sync_ram_if.sv
// dual_port_sync_ram_if
// ---------------------
// Purpose: one request/response port of the dual-port RAM. Each RAM port
//          (A and B) is bound to its own instance of this interface.
// Signals:
//   cs      request strobe (read or write) for this cycle
//   we      1 = write, 0 = read
//   be      byte-lane enables, one bit per 8-bit lane (writes only)
//   addr    word address
//   wdata   write data
//   rdata   read data, holds the last completed read
//   rvalid  one-cycle strobe marking a completed read
// Modports: master drives the request side, slave is the RAM side.

interface dual_port_sync_ram_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
);
    logic                    cs;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rvalid;

    modport master (
        output cs, we, be, addr, wdata,
        input  rdata, rvalid
    );

    modport slave (
        input  cs, we, be, addr, wdata,
        output rdata, rvalid
    );
endinterface

// File: rtl/dual_port_sync_ram.sv
// dual_port_sync_ram
// ------------------
// Purpose: true dual-port synchronous RAM shared between two masters.
//          Both ports read and write independently with byte-lane write
//          enables and a 1- or 2-cycle registered read path. After reset a
//          clear sequencer zeroes every word (optional), during which both
//          ports are ignored and busy is high.
// Ports:
//   clk    clock, everything on the rising edge
//   rst    synchronous active-high reset
//   busy   high while the clear sequence is running
//   a, b   port A / port B request and response bundles (slave modport)
// Parameters:
//   ADDR_WIDTH      address bits per port, DEPTH = 2**ADDR_WIDTH
//   DATA_WIDTH      word width, multiple of 8
//   READ_LATENCY    1 or 2 cycles from request edge to rdata/rvalid
//   RDW_MODE        same-address read vs. other-port write: 0 old, 1 new
//   CLEAR_ON_RESET  1 = zero the array after reset, 0 = leave contents

module dual_port_sync_ram #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    dual_port_sync_ram_if.slave   a,
    dual_port_sync_ram_if.slave   b
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LANES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    // Reject parameter sets the datapath cannot implement.
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_data_width
        $error("dual_port_sync_ram: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("dual_port_sync_ram: READ_LATENCY must be 1 or 2");
    end

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clr_ptr;
    logic                    port_en;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    a_wr;
    logic                    a_rd;
    logic                    b_wr;
    logic                    b_rd;
    logic [DATA_WIDTH-1:0]   a_read_word;
    logic [DATA_WIDTH-1:0]   b_read_word;

    logic [DATA_WIDTH-1:0]   a_stage_data;
    logic [DATA_WIDTH-1:0]   b_stage_data;
    logic                    a_stage_valid;
    logic                    b_stage_valid;
    logic [DATA_WIDTH-1:0]   a_rdata_q;
    logic [DATA_WIDTH-1:0]   b_rdata_q;
    logic                    a_rvalid_q;
    logic                    b_rvalid_q;

    // State register and clear pointer. The pointer only advances while
    // clearing; its natural wrap back to 0 after the last word is harmless
    // because the FSM leaves CLEAR on that same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_ptr <= '0;
        end else begin
            state <= state_next;
            if (state == ST_CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
            end
        end
    end

    // Next state: CLEAR ends on the edge that zeroes the last word.
    always_comb begin
        state_next = state;
        if (state == ST_CLEAR && clr_ptr == LAST_ADDR) begin
            state_next = ST_IDLE;
        end
    end

    // FSM outputs: ports are only serviced outside the clear sequence.
    always_comb begin
        busy    = (state == ST_CLEAR);
        port_en = (state == ST_IDLE);
    end

    assign a_wr = port_en & a.cs &  a.we;
    assign a_rd = port_en & a.cs & ~a.we;
    assign b_wr = port_en & b.cs &  b.we;
    assign b_rd = port_en & b.cs & ~b.we;

    // Array update. B's lanes are applied before A's so that on a shared
    // address A's enabled lanes override, while B's other lanes still land.
    // Contents are never reset; rst only blocks writes on its own edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (busy) begin
                mem[clr_ptr] <= '0;
            end else begin
                for (int i = 0; i < LANES; i++) begin
                    if (b_wr && b.be[i]) begin
                        mem[b.addr][8*i +: 8] <= b.wdata[8*i +: 8];
                    end
                end
                for (int i = 0; i < LANES; i++) begin
                    if (a_wr && a.be[i]) begin
                        mem[a.addr][8*i +: 8] <= a.wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    // Word captured by each port's read. In new-data mode the other port's
    // same-cycle write lanes are forwarded so the read sees the merged word.
    always_comb begin
        a_read_word = mem[a.addr];
        b_read_word = mem[b.addr];
        if (RDW_MODE != 0) begin
            for (int i = 0; i < LANES; i++) begin
                if (b_wr && b.be[i] && b.addr == a.addr) begin
                    a_read_word[8*i +: 8] = b.wdata[8*i +: 8];
                end
                if (a_wr && a.be[i] && a.addr == b.addr) begin
                    b_read_word[8*i +: 8] = a.wdata[8*i +: 8];
                end
            end
        end
    end

    // Port A read pipeline. The stage register is the extra cycle used only
    // when READ_LATENCY is 2. rdata updates only when a read completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_stage_data  <= '0;
            a_stage_valid <= 1'b0;
            a_rdata_q     <= '0;
            a_rvalid_q    <= 1'b0;
        end else begin
            a_stage_valid <= a_rd;
            if (a_rd) begin
                a_stage_data <= a_read_word;
            end
            if (READ_LATENCY == 1) begin
                a_rvalid_q <= a_rd;
                if (a_rd) begin
                    a_rdata_q <= a_read_word;
                end
            end else begin
                a_rvalid_q <= a_stage_valid;
                if (a_stage_valid) begin
                    a_rdata_q <= a_stage_data;
                end
            end
        end
    end

    // Port B read pipeline, identical in structure to port A.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_stage_data  <= '0;
            b_stage_valid <= 1'b0;
            b_rdata_q     <= '0;
            b_rvalid_q    <= 1'b0;
        end else begin
            b_stage_valid <= b_rd;
            if (b_rd) begin
                b_stage_data <= b_read_word;
            end
            if (READ_LATENCY == 1) begin
                b_rvalid_q <= b_rd;
                if (b_rd) begin
                    b_rdata_q <= b_read_word;
                end
            end else begin
                b_rvalid_q <= b_stage_valid;
                if (b_stage_valid) begin
                    b_rdata_q <= b_stage_data;
                end
            end
        end
    end

    assign a.rdata  = a_rdata_q;
    assign a.rvalid = a_rvalid_q;
    assign b.rdata  = b_rdata_q;
    assign b.rvalid = b_rvalid_q;

endmodule

// File: tb/tb_dual_port_sync_ram.sv
// tb_dual_port_sync_ram
// ---------------------
// Purpose: directed self-checking bench for dual_port_sync_ram.
// Three instances, all ADDR_WIDTH 4 / DATA_WIDTH 32:
//   dut 0: READ_LATENCY 1, RDW_MODE 0 (old data), CLEAR_ON_RESET 1
//   dut 1: READ_LATENCY 2, RDW_MODE 1 (new data), CLEAR_ON_RESET 1
//   dut 2: READ_LATENCY 1, RDW_MODE 0,            CLEAR_ON_RESET 0
// Inputs are driven and outputs sampled 1 ns after each rising edge.

module tb_dual_port_sync_ram;

    localparam int AW   = 4;
    localparam int DW   = 32;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst      [NDUT];
    logic          busy     [NDUT];
    logic          a_cs     [NDUT];
    logic          a_we     [NDUT];
    logic [3:0]    a_be     [NDUT];
    logic [AW-1:0] a_addr   [NDUT];
    logic [DW-1:0] a_wdata  [NDUT];
    logic [DW-1:0] a_rdata  [NDUT];
    logic          a_rvalid [NDUT];
    logic          b_cs     [NDUT];
    logic          b_we     [NDUT];
    logic [3:0]    b_be     [NDUT];
    logic [AW-1:0] b_addr   [NDUT];
    logic [DW-1:0] b_wdata  [NDUT];
    logic [DW-1:0] b_rdata  [NDUT];
    logic          b_rvalid [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dual_port_sync_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) a_bus ();
        dual_port_sync_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b_bus ();

        assign a_bus.cs    = a_cs[g];
        assign a_bus.we    = a_we[g];
        assign a_bus.be    = a_be[g];
        assign a_bus.addr  = a_addr[g];
        assign a_bus.wdata = a_wdata[g];
        assign a_rdata[g]  = a_bus.rdata;
        assign a_rvalid[g] = a_bus.rvalid;
        assign b_bus.cs    = b_cs[g];
        assign b_bus.we    = b_we[g];
        assign b_bus.be    = b_be[g];
        assign b_bus.addr  = b_addr[g];
        assign b_bus.wdata = b_wdata[g];
        assign b_rdata[g]  = b_bus.rdata;
        assign b_rvalid[g] = b_bus.rvalid;

        dual_port_sync_ram #(
            .ADDR_WIDTH     (AW),
            .DATA_WIDTH     (DW),
            .READ_LATENCY   ((g == 1) ? 2 : 1),
            .RDW_MODE       ((g == 1) ? 1 : 0),
            .CLEAR_ON_RESET ((g == 2) ? 0 : 1)
        ) dut (
            .clk  (clk),
            .rst  (rst[g]),
            .busy (busy[g]),
            .a    (a_bus),
            .b    (b_bus)
        );
    end

    int compareCount = 0;
    int failCount    = 0;

    function automatic int latencyOf(input int d);
        return (d == 1) ? 2 : 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int d, input bit onB, input logic cs,
                                 input logic we, input logic [3:0] be,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (onB) begin
            b_cs[d] = cs; b_we[d] = we; b_be[d] = be; b_addr[d] = addr; b_wdata[d] = wdata;
        end else begin
            a_cs[d] = cs; a_we[d] = we; a_be[d] = be; a_addr[d] = addr; a_wdata[d] = wdata;
        end
    endtask

    task automatic idle(input int d);
        applyStimulus(d, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0);
        applyStimulus(d, 1'b1, 1'b0, 1'b0, 4'h0, '0, '0);
    endtask

    task automatic writeWord(input int d, input bit onB, input logic [3:0] be,
                             input logic [AW-1:0] addr, input logic [DW-1:0] data);
        applyStimulus(d, onB, 1'b1, 1'b1, be, addr, data);
        tick();
        idle(d);
    endtask

    task automatic readWord(input int d, input bit onB, input logic [AW-1:0] addr,
                            output logic [DW-1:0] data, output logic valid);
        applyStimulus(d, onB, 1'b1, 1'b0, 4'h0, addr, '0);
        tick();
        idle(d);
        if (latencyOf(d) == 2) tick();
        data  = onB ? b_rdata[d] : a_rdata[d];
        valid = onB ? b_rvalid[d] : a_rvalid[d];
    endtask

    // Counts samples with busy high, starting at the release sample.
    task automatic countBusy(input int d, output int cnt);
        cnt = 0;
        while (busy[d] && cnt < 200) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] vals [16];
        logic [DW-1:0] rd;
        logic          rv;
        int            cnt;
        logic [DW-1:0] expOld;

        for (int d = 0; d < NDUT; d++) begin
            rst[d] = 1'b1;
            idle(d);
        end
        for (int i = 0; i < 16; i++) vals[i] = $urandom;

        // Reset state
        tick();
        tick();
        checkOutput("rst_busy0", 32'(busy[0]), 32'd1);
        checkOutput("rst_busy1", 32'(busy[1]), 32'd1);
        checkOutput("rst_busy2", 32'(busy[2]), 32'd0);
        checkOutput("rst_a_rvalid0", 32'(a_rvalid[0]), 32'd0);
        checkOutput("rst_a_rdata0", a_rdata[0], 32'd0);
        checkOutput("rst_b_rdata1", b_rdata[1], 32'd0);
        for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;

        // Clear sequence length; a write in the last busy cycle must be lost
        cnt = 0;
        while (busy[0] && cnt < 200) begin
            if (cnt == 15) applyStimulus(0, 1'b0, 1'b1, 1'b1, 4'hF, 4'd0, 32'hDEADBEEF);
            else idle(0);
            cnt++;
            tick();
        end
        idle(0);
        checkOutput("clear_len", 32'(cnt), 32'd16);
        checkOutput("clear_busy1_done", 32'(busy[1]), 32'd0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1'b0, 1'b1, 1'b0, 4'h0, AW'(i), '0);
            tick();
            checkOutput($sformatf("clear_rd%0d", i), a_rdata[0], 32'd0);
            checkOutput($sformatf("clear_rv%0d", i), 32'(a_rvalid[0]), 32'd1);
        end
        idle(0);
        tick();
        checkOutput("clear_rv_drop", 32'(a_rvalid[0]), 32'd0);

        // Write on A, back-to-back reads on B, latency 1
        for (int i = 0; i < 16; i++) writeWord(0, 1'b0, 4'hF, AW'(i), vals[i]);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1'b1, 1'b1, 1'b0, 4'h0, AW'(i), '0);
            tick();
            checkOutput($sformatf("l1_rd%0d", i), b_rdata[0], vals[i]);
            checkOutput($sformatf("l1_rv%0d", i), 32'(b_rvalid[0]), 32'd1);
        end
        idle(0);
        tick();
        checkOutput("l1_rv_drop", 32'(b_rvalid[0]), 32'd0);
        checkOutput("l1_hold", b_rdata[0], vals[15]);

        // Same on latency 2: nothing after one cycle, then one word per cycle
        for (int i = 0; i < 16; i++) writeWord(1, 1'b0, 4'hF, AW'(i), vals[i]);
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) applyStimulus(1, 1'b1, 1'b1, 1'b0, 4'h0, AW'(i), '0);
            else idle(1);
            tick();
            if (i == 0) begin
                checkOutput("l2_rv_early", 32'(b_rvalid[1]), 32'd0);
            end else begin
                checkOutput($sformatf("l2_rd%0d", i - 1), b_rdata[1], vals[i-1]);
                checkOutput($sformatf("l2_rv%0d", i - 1), 32'(b_rvalid[1]), 32'd1);
            end
        end
        tick();
        checkOutput("l2_rv_drop", 32'(b_rvalid[1]), 32'd0);
        checkOutput("l2_hold", b_rdata[1], vals[15]);

        // Byte enables
        writeWord(0, 1'b0, 4'hF, 4'd7, 32'hAABBCCDD);
        writeWord(0, 1'b0, 4'h5, 4'd7, 32'h11223344);
        readWord(0, 1'b0, 4'd7, rd, rv);
        checkOutput("be_merge", rd, 32'hAA22CC44);
        writeWord(0, 1'b0, 4'h0, 4'd7, 32'hFFFFFFFF);
        readWord(0, 1'b0, 4'd7, rd, rv);
        checkOutput("be_zero", rd, 32'hAA22CC44);
        tick();
        checkOutput("be_rv_pulse", 32'(a_rvalid[0]), 32'd0);

        // Same-address collisions at 0x3 on the old-data and new-data instances
        for (int d = 0; d < 2; d++) begin
            applyStimulus(d, 1'b0, 1'b1, 1'b1, 4'hF, 4'd3, 32'h00000055);
            applyStimulus(d, 1'b1, 1'b1, 1'b1, 4'hF, 4'd3, 32'h00000066);
            tick();
            idle(d);
            readWord(d, 1'b0, 4'd3, rd, rv);
            checkOutput($sformatf("ww_a_wins_d%0d", d), rd, 32'h00000055);

            applyStimulus(d, 1'b0, 1'b1, 1'b1, 4'h1, 4'd3, 32'h000000AA);
            applyStimulus(d, 1'b1, 1'b1, 1'b1, 4'hF, 4'd3, 32'h12345678);
            tick();
            idle(d);
            readWord(d, 1'b0, 4'd3, rd, rv);
            checkOutput($sformatf("ww_lanes_d%0d", d), rd, 32'h123456AA);

            writeWord(d, 1'b0, 4'hF, 4'd3, 32'h00000055);
            applyStimulus(d, 1'b0, 1'b1, 1'b1, 4'hF, 4'd3, 32'h00000077);
            applyStimulus(d, 1'b1, 1'b1, 1'b0, 4'h0, 4'd3, '0);
            tick();
            idle(d);
            if (latencyOf(d) == 2) tick();
            expOld = (d == 1) ? 32'h00000077 : 32'h00000055;
            checkOutput($sformatf("rdw_full_d%0d", d), b_rdata[d], expOld);
            checkOutput($sformatf("rdw_rv_d%0d", d), 32'(b_rvalid[d]), 32'd1);

            applyStimulus(d, 1'b0, 1'b1, 1'b1, 4'h2, 4'd3, 32'h0000AB00);
            applyStimulus(d, 1'b1, 1'b1, 1'b0, 4'h0, 4'd3, '0);
            tick();
            idle(d);
            if (latencyOf(d) == 2) tick();
            expOld = (d == 1) ? 32'h0000AB77 : 32'h00000077;
            checkOutput($sformatf("rdw_lane_d%0d", d), b_rdata[d], expOld);

            applyStimulus(d, 1'b0, 1'b1, 1'b0, 4'h0, 4'd3, '0);
            applyStimulus(d, 1'b1, 1'b1, 1'b0, 4'h0, 4'd3, '0);
            tick();
            idle(d);
            if (latencyOf(d) == 2) tick();
            checkOutput($sformatf("rr_a_d%0d", d), a_rdata[d], 32'h0000AB77);
            checkOutput($sformatf("rr_b_d%0d", d), b_rdata[d], 32'h0000AB77);
        end

        // Reset during clear at clr_ptr 9 restarts the full sequence
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        repeat (9) tick();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        countBusy(0, cnt);
        checkOutput("restart_len", 32'(cnt), 32'd16);
        readWord(0, 1'b0, 4'd12, rd, rv);
        checkOutput("restart_cleared", rd, 32'd0);

        // Reset with a latency-2 read in flight
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 4'h0, 4'd3, '0);
        tick();
        idle(1);
        rst[1] = 1'b1;
        tick();
        checkOutput("flush_rv", 32'(b_rvalid[1]), 32'd0);
        checkOutput("flush_rdata", b_rdata[1], 32'd0);
        rst[1] = 1'b0;
        tick();
        checkOutput("flush_rv_after", 32'(b_rvalid[1]), 32'd0);
        countBusy(1, cnt);
        checkOutput("flush_clear_done", 32'(busy[1]), 32'd0);

        // No clear: write on the first cycle after reset is accepted
        rst[2] = 1'b1;
        tick();
        tick();
        rst[2] = 1'b0;
        checkOutput("noclr_busy", 32'(busy[2]), 32'd0);
        writeWord(2, 1'b0, 4'hF, 4'd9, 32'hCAFEF00D);
        checkOutput("noclr_busy_after", 32'(busy[2]), 32'd0);
        readWord(2, 1'b1, 4'd9, rd, rv);
        checkOutput("noclr_rd", rd, 32'hCAFEF00D);
        checkOutput("noclr_rv", 32'(rv), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
